// File: rtl/grid_drawer.sv
// -----------------------------------------------------------------------------
// grid_drawer
//
// Emits pixel writes for a VGA adapter that outline (and optionally fill) the
// cells of a GRID_W x GRID_H grid of CELL x CELL pixel squares. The grid's
// top-left corner is at (X0, Y0). A request draws either the whole grid or
// one cell. The design writes one pixel per clock while drawing.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request pulse, sampled only when idle
//   full         1 = whole grid, 0 = single cell (cell_col, cell_row)
//   fill         1 = interiors in fill_colour, 0 = interiors black
//   fill_colour  interior colour when fill = 1
//   cell_col     target column for a single-cell request
//   cell_row     target row for a single-cell request
//   busy         high from request acceptance through the completion cycle
//   done         one-cycle completion pulse
//   writeEn      pixel write strobe
//   x, y, colour registered pixel coordinate and colour
// -----------------------------------------------------------------------------
module grid_drawer #(
    parameter int          GRID_W        = 8,
    parameter int          GRID_H        = 8,
    parameter int          CELL          = 8,
    parameter int          X0            = 0,
    parameter int          Y0            = 0,
    parameter logic [2:0]  BORDER_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       full,
    input  logic       fill,
    input  logic [2:0] fill_colour,
    input  logic [3:0] cell_col,
    input  logic [3:0] cell_row,
    output logic       busy,
    output logic       done,
    output logic       writeEn,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);

    localparam logic [3:0] PX_LAST  = 4'(CELL - 1);
    localparam logic [3:0] COL_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg;

    // Request captured at acceptance; the live inputs are ignored afterwards.
    logic       full_reg;
    logic       fill_reg;
    logic [2:0] fill_colour_reg;
    logic [3:0] cell_col_reg;
    logic [3:0] cell_row_reg;

    // Coordinates of the pixel currently presented on the outputs.
    logic [3:0] col_reg;
    logic [3:0] row_reg;
    logic [3:0] px_reg;
    logic [3:0] py_reg;

    logic       busy_reg;
    logic       done_reg;
    logic       write_en_reg;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [2:0] colour_reg;

    // Next-pixel stepping and output-pixel calculation.
    logic       px_last;
    logic       py_last;
    logic       col_last;
    logic       row_last;
    logic       cell_wrap;
    logic       last_pixel;
    logic       req_valid;
    logic [3:0] emit_col;
    logic [3:0] emit_row;
    logic [3:0] emit_px;
    logic [3:0] emit_py;
    logic [7:0] x_next;
    logic [6:0] y_next;
    logic [2:0] colour_next;
    logic       on_border;

    always_comb begin
        px_last    = (px_reg == PX_LAST);
        py_last    = (py_reg == PX_LAST);
        col_last   = (col_reg == COL_LAST);
        row_last   = (row_reg == ROW_LAST);
        cell_wrap  = px_last && py_last;
        // A single-cell request ends at the cell's last pixel; a full grid
        // ends at the last pixel of the bottom-right cell.
        last_pixel = cell_wrap && (!full_reg || (col_last && row_last));

        // Out-of-range single cells are rejected without drawing anything.
        req_valid  = full_reg ||
                     (({1'b0, cell_col_reg} < 5'(GRID_W)) &&
                      ({1'b0, cell_row_reg} < 5'(GRID_H)));

        emit_col = col_reg;
        emit_row = row_reg;
        emit_px  = px_reg;
        emit_py  = py_reg;

        if (state_reg == LOAD) begin
            // First pixel of the request.
            emit_col = full_reg ? 4'd0 : cell_col_reg;
            emit_row = full_reg ? 4'd0 : cell_row_reg;
            emit_px  = 4'd0;
            emit_py  = 4'd0;
        end else begin
            // Step: px innermost, then py, then column, then row.
            emit_px = px_last ? 4'd0 : px_reg + 4'd1;
            if (px_last) begin
                emit_py = py_last ? 4'd0 : py_reg + 4'd1;
            end
            if (cell_wrap && full_reg) begin
                emit_col = col_last ? 4'd0 : col_reg + 4'd1;
                if (col_last) begin
                    emit_row = row_last ? 4'd0 : row_reg + 4'd1;
                end
            end
        end

        // Modular 8/7-bit arithmetic gives the required truncation directly.
        x_next = 8'(X0) + 8'(emit_col) * 8'(CELL) + 8'(emit_px);
        y_next = 7'(Y0) + 7'(emit_row) * 7'(CELL) + 7'(emit_py);

        on_border = (emit_px == 4'd0) || (emit_px == PX_LAST) ||
                    (emit_py == 4'd0) || (emit_py == PX_LAST);
        if (on_border) begin
            colour_next = BORDER_COLOUR;
        end else if (fill_reg) begin
            colour_next = fill_colour_reg;
        end else begin
            colour_next = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            full_reg        <= 1'b0;
            fill_reg        <= 1'b0;
            fill_colour_reg <= 3'b000;
            cell_col_reg    <= 4'd0;
            cell_row_reg    <= 4'd0;
            col_reg         <= 4'd0;
            row_reg         <= 4'd0;
            px_reg          <= 4'd0;
            py_reg          <= 4'd0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            write_en_reg    <= 1'b0;
            x_reg           <= 8'd0;
            y_reg           <= 7'd0;
            colour_reg      <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg     <= 1'b0;
                    write_en_reg <= 1'b0;
                    if (start) begin
                        full_reg        <= full;
                        fill_reg        <= fill;
                        fill_colour_reg <= fill_colour;
                        cell_col_reg    <= cell_col;
                        cell_row_reg    <= cell_row;
                        busy_reg        <= 1'b1;
                        state_reg       <= LOAD;
                    end
                end

                LOAD: begin
                    if (req_valid) begin
                        col_reg      <= emit_col;
                        row_reg      <= emit_row;
                        px_reg       <= emit_px;
                        py_reg       <= emit_py;
                        x_reg        <= x_next;
                        y_reg        <= y_next;
                        colour_reg   <= colour_next;
                        write_en_reg <= 1'b1;
                        state_reg    <= DRAW;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                DRAW: begin
                    if (last_pixel) begin
                        write_en_reg <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        col_reg    <= emit_col;
                        row_reg    <= emit_row;
                        px_reg     <= emit_px;
                        py_reg     <= emit_py;
                        x_reg      <= x_next;
                        y_reg      <= y_next;
                        colour_reg <= colour_next;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign writeEn = write_en_reg;
    assign x       = x_reg;
    assign y       = y_reg;
    assign colour  = colour_reg;

endmodule

// File: doc/grid_drawer.md
GRID_DRAWER -- requirements
Module: grid_drawer

Interface
REQ-001 Parameter GRID_W, default 8, number of cell columns (1..16).
REQ-002 Parameter GRID_H, default 8, number of cell rows (1..16).
REQ-003 Parameter CELL, default 8, cell edge in pixels (3..16); X0+GRID_W*CELL SHALL be <=160 and Y0+GRID_H*CELL SHALL be <=120.
REQ-004 Parameter X0, default 0, grid origin x in pixels.
REQ-005 Parameter Y0, default 0, grid origin y in pixels.
REQ-006 Parameter BORDER_COLOUR, default 3'b111, colour of cell outline pixels.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 clock  in  1  system clock; all state changes on rising edge.
REQ-009 reset  in  1  asynchronous active-high reset.
REQ-010 start  in  1  request pulse; sampled only in IDLE.
REQ-011 full  in  1  1 = draw whole grid, 0 = draw single cell.
REQ-012 fill  in  1  1 = cell interiors in fill_colour, 0 = interiors in 3'b000.
REQ-013 fill_colour  in  3  interior colour when fill=1.
REQ-014 cell_col  in  4  target column when full=0.
REQ-015 cell_row  in  4  target row when full=0.
REQ-016 busy  out  1  high in LOAD, DRAW, DONE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 writeEn  out  1  pixel write strobe to VGA adapter.
REQ-019 x  out  8  pixel x; y  out  7  pixel y; colour  out  3  pixel colour (all registered).

Function
REQ-020 FSM states IDLE, LOAD, DRAW, DONE; IDLE->LOAD on start=1; LOAD->DRAW for a valid request; DRAW->DONE after last pixel; DONE->IDLE unconditionally.
REQ-021 In IDLE with start=1, full, fill, fill_colour, cell_col, cell_row SHALL be latched; later input changes SHALL have no effect on the request.
REQ-022 start SHALL be ignored in LOAD, DRAW and DONE (no queueing).
REQ-023 full=1: cell counters start at col=0,row=0; full=0: start and end at latched cell_col,cell_row.
REQ-024 full=0 with cell_col>=GRID_W or cell_row>=GRID_H: LOAD->DONE directly, zero writeEn cycles, done still pulses.
REQ-025 In DRAW exactly one pixel per cycle, writeEn=1 every DRAW cycle; first write is the cycle after LOAD.
REQ-026 Scan order: within a cell px 0..CELL-1 inner, py 0..CELL-1 outer; cells col inner, row outer.
REQ-027 x = X0+col*CELL+px, y = Y0+row*CELL+py, truncated to 8/7 bits.
REQ-028 colour = BORDER_COLOUR if px==0, px==CELL-1, py==0 or py==CELL-1; else fill_colour if fill=1; else 3'b000.
REQ-029 Writes per request: GRID_W*GRID_H*CELL*CELL (full) or CELL*CELL (single); no pixel repeated or skipped.
REQ-030 done=1 for exactly the cycle in DONE, i.e. the cycle after the last writeEn; writeEn=0 outside DRAW.
REQ-031 Latency: start accepted at edge N -> first writeEn during cycle N+2 -> done during cycle N+2+writes.

Reset
REQ-032 reset=1 SHALL immediately force state IDLE, busy=0, done=0, writeEn=0, x=0, y=0, colour=0, all counters 0, independent of clock.
REQ-033 Reset mid-DRAW SHALL abort the request with no done pulse; next start after release begins a fresh request.

Verification
REQ-034 Defaults, full=1 fill=0 start pulse -> 4096 writes; first (0,0) colour 111; (1,1) colour 000; (7,3) colour 111; last (63,63) colour 111; done the next cycle.
REQ-035 full=0 cell_col=3 cell_row=2 fill=1 fill_colour=100 -> 64 writes, x 24..31, y 16..23; (25,17) colour 100; (24,16) colour 111.
REQ-036 start re-pulsed during DRAW of full grid and in DONE cycle -> still exactly 4096 writes, one done, then start in IDLE accepted.
REQ-037 full=0 cell_col=8 -> busy 2 cycles, done pulse, zero writeEn.
REQ-038 reset asserted between edges at write 100 -> writeEn, busy, x, y, colour 0 without waiting for a clock edge; no done; restart begins at (0,0).
REQ-039 Inputs changed one cycle after start (full=1->0, fill_colour 100->010) -> output identical to the request latched at start.
